// File: rtl/fft_stage_scheduler.sv
// In-place radix-2 FFT stage sequencer: one butterfly read per cycle, writes mirrored PIPE_LAT later.
// Optional stall counter port enabled by defining FFT_SCHED_PERF_EN.
module fft_stage_scheduler #(
   parameter int unsigned N        = 8,
   parameter int unsigned PIPE_LAT = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   hold,
   output logic                   rd_en,
   output logic [$clog2(N)-1:0]   rd_stage,
   output logic [$clog2(N)-2:0]   rd_level,
   output logic                   rd_bank,
   output logic                   wr_en,
   output logic [$clog2(N)-1:0]   wr_stage,
   output logic [$clog2(N)-2:0]   wr_level,
   output logic                   wr_bank,
   output logic                   busy,
   output logic                   done
`ifdef FFT_SCHED_PERF_EN
   ,
   output logic [15:0]            stall_cycles
`endif
);

   localparam int unsigned LOG2N = $clog2(N);
   localparam int unsigned STG_W = LOG2N;
   localparam int unsigned LVL_W = LOG2N - 1;
   localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(LOG2N - 1);
   localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(N / 2 - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t             state_q, state_d;
   logic [STG_W-1:0]   stage_q, stage_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               rd_en_q, rd_en_d;
   logic [STG_W-1:0]   rd_stage_q, rd_stage_d;
   logic [LVL_W-1:0]   rd_level_q, rd_level_d;
   logic               rd_bank_q, rd_bank_d;
   logic               wr_bank_q, wr_bank_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               issue;
   logic               pend;

   logic               sr_vld_q [PIPE_LAT];
   logic               sr_vld_d [PIPE_LAT];
   logic [STG_W-1:0]   sr_stg_q [PIPE_LAT];
   logic [STG_W-1:0]   sr_stg_d [PIPE_LAT];
   logic [LVL_W-1:0]   sr_lvl_q [PIPE_LAT];
   logic [LVL_W-1:0]   sr_lvl_d [PIPE_LAT];

   // Write-side delay line; idle slots carry a zero payload so IDLE shows clean outputs.
   always_comb begin
      sr_vld_d[0] = rd_en_q;
      sr_stg_d[0] = rd_en_q ? rd_stage_q : '0;
      sr_lvl_d[0] = rd_en_q ? rd_level_q : '0;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
         sr_vld_d[i] = sr_vld_q[i-1];
         sr_stg_d[i] = sr_stg_q[i-1];
         sr_lvl_d[i] = sr_lvl_q[i-1];
      end
      wr_bank_d = ~sr_stg_d[PIPE_LAT-1][0];
   end

   // Reads still in flight after this edge; the tail slot retires in the current cycle.
   always_comb begin
      pend = rd_en_q;
      for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
         pend = pend | sr_vld_q[i];
      end
   end

   // Next-state and read-issue decision for the following cycle.
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      level_d    = level_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_en_d    = 1'b0;
      rd_stage_d = rd_stage_q;
      rd_level_d = rd_level_q;
      issue      = 1'b0;
      case (state_q)
         IDLE: begin
            rd_stage_d = '0;
            rd_level_d = '0;
            if (start) begin
               busy_d  = 1'b1;
               stage_d = '0;
               level_d = '0;
               state_d = ISSUE;
               issue   = ~hold;
            end
         end
         ISSUE: issue = ~hold;
         DRAIN: begin
            if (!pend) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
                  stage_d = stage_q + STG_W'(1);
                  level_d = '0;
                  state_d = ISSUE;
                  issue   = ~hold;
               end
            end
         end
         FINISH: begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            rd_stage_d = '0;
            rd_level_d = '0;
         end
         default: state_d = IDLE;
      endcase
      if (issue) begin
         rd_en_d    = 1'b1;
         rd_stage_d = stage_d;
         rd_level_d = level_d;
         if (level_d == LAST_LEVEL) begin
            state_d = DRAIN;
         end else begin
            level_d = level_d + LVL_W'(1);
         end
      end
      rd_bank_d = rd_stage_d[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         stage_q    <= '0;
         level_q    <= '0;
         rd_en_q    <= 1'b0;
         rd_stage_q <= '0;
         rd_level_q <= '0;
         rd_bank_q  <= 1'b0;
         wr_bank_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < int'(PIPE_LAT); i++) begin
            sr_vld_q[i] <= 1'b0;
            sr_stg_q[i] <= '0;
            sr_lvl_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         level_q    <= level_d;
         rd_en_q    <= rd_en_d;
         rd_stage_q <= rd_stage_d;
         rd_level_q <= rd_level_d;
         rd_bank_q  <= rd_bank_d;
         wr_bank_q  <= wr_bank_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         for (int i = 0; i < int'(PIPE_LAT); i++) begin
            sr_vld_q[i] <= sr_vld_d[i];
            sr_stg_q[i] <= sr_stg_d[i];
            sr_lvl_q[i] <= sr_lvl_d[i];
         end
      end
   end

   assign rd_en    = rd_en_q;
   assign rd_stage = rd_stage_q;
   assign rd_level = rd_level_q;
   assign rd_bank  = rd_bank_q;
   assign wr_en    = sr_vld_q[PIPE_LAT-1];
   assign wr_stage = sr_stg_q[PIPE_LAT-1];
   assign wr_level = sr_lvl_q[PIPE_LAT-1];
   assign wr_bank  = wr_bank_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef FFT_SCHED_PERF_EN
   logic [15:0] stall_q, stall_d;

   // Counts busy cycles without a read, excluding the done cycle; saturates.
   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start) begin
         stall_d = '0;
      end else if (busy_q && !rd_en_q && !done_q && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Bench for fft_stage_scheduler: cycle-schedule model compared every cycle, plus literal timing pins.
module tb_fft_stage_scheduler;
   localparam int MAXC = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8_n, start8, hold8;
   logic       rd_en8, rd_bank8, wr_en8, wr_bank8, busy8, done8;
   logic [2:0] rs8, ws8;
   logic [1:0] rl8, wl8;

   logic       rst16_n, start16, hold16;
   logic       rd_en16, rd_bank16, wr_en16, wr_bank16, busy16, done16;
   logic [3:0] rs16, ws16;
   logic [2:0] rl16, wl16;
`ifdef FFT_SCHED_PERF_EN
   logic [15:0] st8, st16;
`endif

   fft_stage_scheduler #(.N(8), .PIPE_LAT(3)) dut8 (
      .clk(clk), .rst_n(rst8_n), .start(start8), .hold(hold8),
      .rd_en(rd_en8), .rd_stage(rs8), .rd_level(rl8), .rd_bank(rd_bank8),
      .wr_en(wr_en8), .wr_stage(ws8), .wr_level(wl8), .wr_bank(wr_bank8),
      .busy(busy8), .done(done8)
`ifdef FFT_SCHED_PERF_EN
      , .stall_cycles(st8)
`endif
   );

   fft_stage_scheduler #(.N(16), .PIPE_LAT(1)) dut16 (
      .clk(clk), .rst_n(rst16_n), .start(start16), .hold(hold16),
      .rd_en(rd_en16), .rd_stage(rs16), .rd_level(rl16), .rd_bank(rd_bank16),
      .wr_en(wr_en16), .wr_stage(ws16), .wr_level(wl16), .wr_bank(wr_bank16),
      .busy(busy16), .done(done16)
`ifdef FFT_SCHED_PERF_EN
      , .stall_cycles(st16)
`endif
   );

   int errors = 0;
   int checks = 0;
   bit e_rd [MAXC];
   bit e_wr [MAXC];
   bit e_busy [MAXC];
   bit e_done [MAXC];
   int e_rs [MAXC];
   int e_rl [MAXC];
   int e_ws [MAXC];
   int e_wl [MAXC];
   bit active = 1'b0;
   bit sel16 = 1'b0;
   int cur_c = 0;
   int obs_done_c;
   int obs_last_rd0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cur_c, act, exp);
      end
   endtask

   // Schedule model: a read lands in cycle t only if hold was low in cycle t-1; a new stage
   // may start only after the previous stage's last write (last read + p) has gone.
   task automatic build(input int n, input int p, input int hlo, input int hhi, input int rcyc);
      int lg, t, last;
      for (int i = 0; i < MAXC; i++) begin
         e_rd[i] = 0; e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0;
         e_rs[i] = 0; e_rl[i] = 0; e_ws[i] = 0; e_wl[i] = 0;
      end
      lg = $clog2(n);
      t = 1;
      last = 0;
      for (int s = 0; s < lg; s++) begin
         for (int l = 0; l < n / 2; l++) begin
            while (t - 1 >= hlo && t - 1 <= hhi) t++;
            e_rd[t] = 1; e_rs[t] = s; e_rl[t] = l;
            e_wr[t+p] = 1; e_ws[t+p] = s; e_wl[t+p] = l;
            last = t;
            t++;
         end
         t = last + p + 1;
      end
      for (int i = 1; i <= last + p + 1; i++) e_busy[i] = 1;
      e_done[last+p+1] = 1;
      if (rcyc >= 0) begin
         for (int i = rcyc + 1; i < MAXC; i++) begin
            e_rd[i] = 0; e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0;
         end
      end
   endtask

   task automatic run(input bit is16, input int n, input int p, input int hlo, input int hhi,
                      input int s1, input int s2, input int rcyc, input int len);
      bit st, hd, rs;
      build(n, p, hlo, hhi, rcyc);
      sel16 = is16;
      obs_done_c = -1;
      obs_last_rd0 = -1;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         cur_c = c;
         active = 1'b1;
         st = (c == 0) || (c == s1) || (c == s2);
         hd = (c >= hlo) && (c <= hhi);
         rs = (c != rcyc);
         if (is16) begin start16 = st; hold16 = hd; rst16_n = rs; end
         else begin start8 = st; hold8 = hd; rst8_n = rs; end
      end
      @(posedge clk); #1;
      active = 1'b0;
      start8 = 0; hold8 = 0; rst8_n = 1;
      start16 = 0; hold16 = 0; rst16_n = 1;
   endtask

   // Per-cycle comparison against the model for the selected instance.
   always @(negedge clk) begin
      int c, a_rd, a_rs, a_rl, a_rb, a_wr, a_ws, a_wl, a_wb, a_busy, a_done;
      if (active) begin
         c      = cur_c;
         a_rd   = sel16 ? int'(rd_en16)   : int'(rd_en8);
         a_rs   = sel16 ? int'(rs16)      : int'(rs8);
         a_rl   = sel16 ? int'(rl16)      : int'(rl8);
         a_rb   = sel16 ? int'(rd_bank16) : int'(rd_bank8);
         a_wr   = sel16 ? int'(wr_en16)   : int'(wr_en8);
         a_ws   = sel16 ? int'(ws16)      : int'(ws8);
         a_wl   = sel16 ? int'(wl16)      : int'(wl8);
         a_wb   = sel16 ? int'(wr_bank16) : int'(wr_bank8);
         a_busy = sel16 ? int'(busy16)    : int'(busy8);
         a_done = sel16 ? int'(done16)    : int'(done8);
         check("rd_en", a_rd, int'(e_rd[c]));
         check("wr_en", a_wr, int'(e_wr[c]));
         check("busy", a_busy, int'(e_busy[c]));
         check("done", a_done, int'(e_done[c]));
         if (e_rd[c]) begin
            check("rd_stage", a_rs, e_rs[c]);
            check("rd_level", a_rl, e_rl[c]);
            check("rd_bank", a_rb, e_rs[c] % 2);
         end
         if (e_wr[c]) begin
            check("wr_stage", a_ws, e_ws[c]);
            check("wr_level", a_wl, e_wl[c]);
            check("wr_bank", a_wb, 1 - (e_ws[c] % 2));
         end
         if (!e_busy[c]) begin
            check("idle_rd_stage", a_rs, 0);
            check("idle_rd_level", a_rl, 0);
            check("idle_wr_stage", a_ws, 0);
            check("idle_wr_level", a_wl, 0);
            check("idle_wr_bank", a_wb, 1);
         end
         if (a_rd == 1 && a_wr == 1) check("bank_conflict", int'(a_rb != a_wb), 1);
         if (a_done == 1) obs_done_c = c;
         if (a_rd == 1 && a_rs == 0) obs_last_rd0 = c;
      end
   end

   initial begin
      rst8_n = 0; start8 = 0; hold8 = 0;
      rst16_n = 0; start16 = 0; hold16 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_en", int'(rd_en8), 0);
      check("reset_wr_en", int'(wr_en8), 0);
      check("reset_busy", int'(busy8), 0);
      check("reset_done", int'(done8), 0);
      check("reset_wr_bank", int'(wr_bank8), 1);
      check("reset_rd_bank", int'(rd_bank8), 0);
      check("reset16_wr_bank", int'(wr_bank16), 1);
`ifdef FFT_SCHED_PERF_EN
      check("reset_stall", int'(st8), 0);
`endif
      rst8_n = 1; rst16_n = 1;

      run(0, 8, 3, -1, -1, -1, -1, -1, 26);
      check("base_done_cycle", obs_done_c, 22);
      check("base_last_stage0_read", obs_last_rd0, 4);
`ifdef FFT_SCHED_PERF_EN
      check("base_stall", int'(st8), 9);
`endif

      run(0, 8, 3, 2, 3, -1, -1, -1, 28);
      check("hold_done_cycle", obs_done_c, 24);
      check("hold_last_stage0_read", obs_last_rd0, 6);
`ifdef FFT_SCHED_PERF_EN
      check("hold_stall", int'(st8), 11);
`endif

      run(0, 8, 3, -1, -1, 5, 12, -1, 26);
      check("restart_ignored_done_cycle", obs_done_c, 22);
`ifdef FFT_SCHED_PERF_EN
      check("restart_ignored_stall", int'(st8), 9);
`endif

      run(0, 8, 3, -1, -1, -1, -1, 10, 16);
      check("reset_mid_no_done", obs_done_c, -1);
      check("reset_mid_busy", int'(busy8), 0);
`ifdef FFT_SCHED_PERF_EN
      check("reset_mid_stall", int'(st8), 0);
`endif

      run(0, 8, 3, -1, -1, -1, -1, -1, 26);
      check("after_reset_done_cycle", obs_done_c, 22);

      run(1, 16, 1, -1, -1, -1, -1, -1, 41);
      check("n16_done_cycle", obs_done_c, 37);
      check("n16_last_stage0_read", obs_last_rd0, 8);
`ifdef FFT_SCHED_PERF_EN
      check("n16_stall", int'(st16), 4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
